// File: rtl/pipe_d2e.sv
// -----------------------------------------------------------------------------
// pipe_d2e : decode-to-execute pipeline register of the 5-stage MIPS core.
//
// Captures the decoded instruction, PC+8, both forwarded register operands and
// the extended immediate, and presents them to EX one cycle later. It also:
//   - inserts a NOP bubble when decode is stalled or flushed,
//   - holds its contents while EX is stalled (mult/div busy),
//   - ages Tnew by one stage for the hazard unit,
//   - counts inserted bubbles in a saturating statistics counter.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   hold_e                EX stalled: keep every output (bubble_e ignored)
//   bubble_e              load a NOP bubble into EX on this edge
//   instr_d, pc8_d        decode instruction word and its PC+8
//   rs_data_d, rt_data_d  forwarded register operands
//   imm_d                 32-bit extended immediate (passed bit-exact)
//   wreg_d, tnew_d        destination register and Tnew measured in D
//   instr_e .. tnew_e     registered copies presented to EX
//   valid_e               1 = real instruction, 0 = bubble
//   bubble_cnt            bubbles inserted since reset, saturating
// -----------------------------------------------------------------------------
module pipe_d2e #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold_e,
    input  logic             bubble_e,
    input  logic [31:0]      instr_d,
    input  logic [31:0]      pc8_d,
    input  logic [31:0]      rs_data_d,
    input  logic [31:0]      rt_data_d,
    input  logic [31:0]      imm_d,
    input  logic [4:0]       wreg_d,
    input  logic [1:0]       tnew_d,
    output logic [31:0]      instr_e,
    output logic [31:0]      pc8_e,
    output logic [31:0]      rs_data_e,
    output logic [31:0]      rt_data_e,
    output logic [31:0]      imm_e,
    output logic [4:0]       wreg_e,
    output logic [1:0]       tnew_e,
    output logic             valid_e,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_instr;
    logic [31:0]      r_pc8;
    logic [31:0]      r_rs;
    logic [31:0]      r_rt;
    logic [31:0]      r_imm;
    logic [4:0]       r_wreg;
    logic [1:0]       r_tnew;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_instr;
    logic [31:0]      w_pc8;
    logic [31:0]      w_rs;
    logic [31:0]      w_rt;
    logic [31:0]      w_imm;
    logic [4:0]       w_wreg;
    logic [1:0]       w_tnew;
    logic             w_valid;
    logic [CNT_W-1:0] w_cnt;
    logic [1:0]       w_tnew_aged;
    logic [CNT_W-1:0] w_cnt_inc;

    // Tnew ages by one stage on entry to EX; a result already available stays at 0.
    always_comb begin
        if (tnew_d == 2'd0) begin
            w_tnew_aged = 2'd0;
        end else begin
            w_tnew_aged = tnew_d - 2'd1;
        end
    end

    // Saturating increment of the bubble counter: it sticks at all-ones.
    always_comb begin
        if (r_cnt == CNT_MAX) begin
            w_cnt_inc = r_cnt;
        end else begin
            w_cnt_inc = r_cnt + CNT_ONE;
        end
    end

    // Next-state selection with priority hold > bubble > load.
    always_comb begin
        w_instr = r_instr;
        w_pc8   = r_pc8;
        w_rs    = r_rs;
        w_rt    = r_rt;
        w_imm   = r_imm;
        w_wreg  = r_wreg;
        w_tnew  = r_tnew;
        w_valid = r_valid;
        w_cnt   = r_cnt;
        if (hold_e) begin
            w_cnt = r_cnt;
        end else if (bubble_e) begin
            // wreg is forced to 0 so the hazard unit can never forward from a bubble.
            w_instr = NOP_INSTR;
            w_pc8   = 32'h0000_0000;
            w_rs    = 32'h0000_0000;
            w_rt    = 32'h0000_0000;
            w_imm   = 32'h0000_0000;
            w_wreg  = 5'd0;
            w_tnew  = 2'd0;
            w_valid = 1'b0;
            w_cnt   = w_cnt_inc;
        end else begin
            w_instr = instr_d;
            w_pc8   = pc8_d;
            w_rs    = rs_data_d;
            w_rt    = rt_data_d;
            w_imm   = imm_d;
            w_wreg  = wreg_d;
            w_tnew  = w_tnew_aged;
            w_valid = 1'b1;
            w_cnt   = r_cnt;
        end
    end

    // Pipeline register; reset clears to a bubble state without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= NOP_INSTR;
            r_pc8   <= 32'h0000_0000;
            r_rs    <= 32'h0000_0000;
            r_rt    <= 32'h0000_0000;
            r_imm   <= 32'h0000_0000;
            r_wreg  <= 5'd0;
            r_tnew  <= 2'd0;
            r_valid <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_instr <= w_instr;
            r_pc8   <= w_pc8;
            r_rs    <= w_rs;
            r_rt    <= w_rt;
            r_imm   <= w_imm;
            r_wreg  <= w_wreg;
            r_tnew  <= w_tnew;
            r_valid <= w_valid;
            r_cnt   <= w_cnt;
        end
    end

    assign instr_e    = r_instr;
    assign pc8_e      = r_pc8;
    assign rs_data_e  = r_rs;
    assign rt_data_e  = r_rt;
    assign imm_e      = r_imm;
    assign wreg_e     = r_wreg;
    assign tnew_e     = r_tnew;
    assign valid_e    = r_valid;
    assign bubble_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_d2e.sv
module tb_pipe_d2e;

    logic        clk;
    logic        reset;
    logic        hold_e;
    logic        bubble_e;
    logic [31:0] instr_d;
    logic [31:0] pc8_d;
    logic [31:0] rs_data_d;
    logic [31:0] rt_data_d;
    logic [31:0] imm_d;
    logic [4:0]  wreg_d;
    logic [1:0]  tnew_d;
    logic [31:0] instr_e;
    logic [31:0] pc8_e;
    logic [31:0] rs_data_e;
    logic [31:0] rt_data_e;
    logic [31:0] imm_e;
    logic [4:0]  wreg_e;
    logic [1:0]  tnew_e;
    logic        valid_e;
    logic [15:0] bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_d2e #(.NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .hold_e(hold_e), .bubble_e(bubble_e),
        .instr_d(instr_d), .pc8_d(pc8_d), .rs_data_d(rs_data_d), .rt_data_d(rt_data_d),
        .imm_d(imm_d), .wreg_d(wreg_d), .tnew_d(tnew_d),
        .instr_e(instr_e), .pc8_e(pc8_e), .rs_data_e(rs_data_e), .rt_data_e(rt_data_e),
        .imm_e(imm_e), .wreg_e(wreg_e), .tnew_e(tnew_e), .valid_e(valid_e),
        .bubble_cnt(bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference state (what EX should be holding).
    logic [31:0] m_instr, m_pc8, m_rs, m_rt, m_imm;
    int          m_wreg, m_tnew, m_valid, m_cnt;

    typedef struct packed {
        logic        hold;
        logic        bubble;
        logic [31:0] instr;
        logic [31:0] pc8;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  wreg;
        logic [1:0]  tnew;
        logic [31:0] e_instr;
        logic [31:0] e_pc8;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_imm;
        logic [4:0]  e_wreg;
        logic [1:0]  e_tnew;
        logic        e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                             input logic [31:0] ers, input logic [31:0] ert, input logic [31:0] eim,
                             input logic [4:0] ew, input logic [1:0] et, input logic ev,
                             input logic [15:0] ec);
        chk({tag, ".instr"}, {32'h0, instr_e}, {32'h0, ei});
        chk({tag, ".pc8"},   {32'h0, pc8_e}, {32'h0, ep});
        chk({tag, ".rs"},    {32'h0, rs_data_e}, {32'h0, ers});
        chk({tag, ".rt"},    {32'h0, rt_data_e}, {32'h0, ert});
        chk({tag, ".imm"},   {32'h0, imm_e}, {32'h0, eim});
        chk({tag, ".wreg"},  {59'h0, wreg_e}, {59'h0, ew});
        chk({tag, ".tnew"},  {62'h0, tnew_e}, {62'h0, et});
        chk({tag, ".valid"}, {63'h0, valid_e}, {63'h0, ev});
        chk({tag, ".cnt"},   {48'h0, bubble_cnt}, {48'h0, ec});
    endtask

    task automatic check_model(input string tag);
        check_all(tag, m_instr, m_pc8, m_rs, m_rt, m_imm, m_wreg[4:0], m_tnew[1:0],
                  m_valid[0], m_cnt[15:0]);
        // A bubble must never advertise a destination register.
        if (valid_e === 1'b0) chk({tag, ".bubble_wreg"}, {59'h0, wreg_e}, 64'h0);
    endtask

    task automatic drive(input logic h, input logic b, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im,
                         input logic [4:0] w, input logic [1:0] t);
        hold_e = h; bubble_e = b; instr_d = i; pc8_d = p;
        rs_data_d = rs; rt_data_d = rt; imm_d = im; wreg_d = w; tnew_d = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_instr = 32'h0; m_pc8 = 32'h0; m_rs = 32'h0; m_rt = 32'h0; m_imm = 32'h0;
        m_wreg = 0; m_tnew = 0; m_valid = 0; m_cnt = 0;
    endtask

    // Reference rules for one clock edge, using the currently driven inputs.
    task automatic model_edge();
        if (hold_e) begin
            // nothing moves
        end else if (bubble_e) begin
            m_instr = 32'h0; m_pc8 = 32'h0; m_rs = 32'h0; m_rt = 32'h0; m_imm = 32'h0;
            m_wreg = 0; m_tnew = 0; m_valid = 0;
            m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        end else begin
            m_instr = instr_d; m_pc8 = pc8_d; m_rs = rs_data_d; m_rt = rt_data_d;
            m_imm = imm_d; m_wreg = int'(wreg_d); m_valid = 1;
            m_tnew = (int'(tnew_d) - 1 < 0) ? 0 : int'(tnew_d) - 1;
        end
    endtask

    // Assert reset away from a clock edge and verify outputs clear before the next edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0);

        // Reset applied before the first clock edge: asynchronous clear.
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_model("reset_async");
        step();
        step();
        reset = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 32'h2408_FFFF, 32'h100, 32'h11, 32'h22, 32'hFFFF_FFFF, 5'd8, 2'd1,
                    32'h2408_FFFF, 32'h100, 32'h11, 32'h22, 32'hFFFF_FFFF, 5'd8, 2'd0, 1'b1, 16'd0};
        vecs[1] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 32'h104, 32'h33, 32'h44, 32'h1234, 5'd9, 2'd3,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 16'd1};
        vecs[2] = '{1'b0, 1'b1, 32'hCAFE_F00D, 32'h108, 32'h35, 32'h45, 32'h5678, 5'd10, 2'd2,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 16'd2};
        vecs[3] = '{1'b0, 1'b1, 32'h1111_2222, 32'h10C, 32'h37, 32'h47, 32'h9ABC, 5'd11, 2'd1,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 16'd3};
        vecs[4] = '{1'b0, 1'b0, 32'h8C22_0004, 32'h110, 32'h55, 32'h66, 32'h4, 5'd2, 2'd0,
                    32'h8C22_0004, 32'h110, 32'h55, 32'h66, 32'h4, 5'd2, 2'd0, 1'b1, 16'd3};
        vecs[5] = '{1'b1, 1'b1, 32'h1234_5678, 32'h114, 32'h77, 32'h88, 32'hABCD, 5'd5, 2'd2,
                    32'h8C22_0004, 32'h110, 32'h55, 32'h66, 32'h4, 5'd2, 2'd0, 1'b1, 16'd3};
        vecs[6] = '{1'b0, 1'b0, 32'h0C00_0010, 32'h118, 32'h99, 32'hAA, 32'h10, 5'd31, 2'd2,
                    32'h0C00_0010, 32'h118, 32'h99, 32'hAA, 32'h10, 5'd31, 2'd1, 1'b1, 16'd3};
        vecs[7] = '{1'b0, 1'b0, 32'h0085_1020, 32'h11C, 32'hBB, 32'hCC, 32'hFFFF_8000, 5'd2, 2'd3,
                    32'h0085_1020, 32'h11C, 32'hBB, 32'hCC, 32'hFFFF_8000, 5'd2, 2'd2, 1'b1, 16'd3};
        vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h120, 32'h1, 32'h1, 32'h1, 5'd1, 2'd1,
                    32'h0085_1020, 32'h11C, 32'hBB, 32'hCC, 32'hFFFF_8000, 5'd2, 2'd2, 1'b1, 16'd3};
        vecs[9] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h124, 32'h2, 32'h2, 32'h2, 5'd3, 2'd3,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 16'd4};

        for (int k = 0; k < 10; k++) begin
            drive(vecs[k].hold, vecs[k].bubble, vecs[k].instr, vecs[k].pc8, vecs[k].rs,
                  vecs[k].rt, vecs[k].imm, vecs[k].wreg, vecs[k].tnew);
            step();
            check_all($sformatf("vec%0d", k), vecs[k].e_instr, vecs[k].e_pc8, vecs[k].e_rs,
                      vecs[k].e_rt, vecs[k].e_imm, vecs[k].e_wreg, vecs[k].e_tnew,
                      vecs[k].e_valid, vecs[k].e_cnt);
        end

        // Mid-stream reset: load a real instruction, then reset between edges.
        drive(1'b0, 1'b0, 32'hAC43_0008, 32'h200, 32'h5, 32'h6, 32'h8, 5'd4, 2'd2);
        step();
        chk("mid.valid_before", {63'h0, valid_e}, 64'h1);
        do_reset("mid_reset");
        // First edge after reset release is an ordinary load.
        drive(1'b0, 1'b0, 32'h2402_0007, 32'h208, 32'h9, 32'hA, 32'h7, 5'd2, 2'd1);
        model_edge();
        step();
        check_model("post_reset_load");

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom, $urandom,
                  $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)));
            model_edge();
            step();
            check_model($sformatf("rnd%0d", k));
        end

        // Counter saturation: 65534 bubbles to FFFE, then 3 more stay at FFFF.
        do_reset("sat_reset");
        drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0);
        for (int k = 0; k < 65534; k++) step();
        chk("sat.fffe", {48'h0, bubble_cnt}, 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("sat.ffff%0d", k), {48'h0, bubble_cnt}, 64'hFFFF);
        end
        drive(1'b0, 1'b0, 32'h3C01_1234, 32'h300, 32'h1, 32'h2, 32'h1234_0000, 5'd1, 2'd0);
        step();
        chk("sat.after_load", {48'h0, bubble_cnt}, 64'hFFFF);
        chk("sat.load_valid", {63'h0, valid_e}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
